// File: rtl/axis_capture_ptr_if.sv
// AXI4-Stream beat bundle (tdata/tvalid/tready) used by the capture block.
// master drives tdata/tvalid and samples tready; slave is the reverse.
interface axis_capture_ptr_if #(
    parameter int DATA_W = 512
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_capture_ptr.sv
// Pointer-driven AXIS -> BRAM capture: writes beats from start_ptr up to
// (excluding) stop_ptr, one-shot or as a ring; armed by a GPIO enable edge.
// Ports: aclk/areset; s_axis (slave stream); enable/cont/start_ptr/stop_ptr
// (GPIO control); mem_we/mem_addr/mem_wdata (memory write port);
// busy/done/beat_cnt (status).
module axis_capture_ptr #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 13
) (
    input  logic              aclk,
    input  logic              areset,
    axis_capture_ptr_if.slave s_axis,
    input  logic              enable,
    input  logic              cont,
    input  logic [ADDR_W-1:0] start_ptr,
    input  logic [ADDR_W-1:0] stop_ptr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                en_q;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   stop_q, stop_d;
    logic                cont_q, cont_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    logic                rise;
    logic                accept;
    logic [ADDR_W-1:0]   ptr_inc;

    assign rise    = enable & ~en_q;
    assign accept  = s_axis.tvalid & (state_q == ST_CAPTURE);
    assign ptr_inc = ptr_q + ADDR_W'(1);

    assign s_axis.tready = (state_q == ST_CAPTURE);
    assign busy          = (state_q == ST_CAPTURE);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign done          = done_q;
    assign beat_cnt      = cnt_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        start_d = start_q;
        stop_d  = stop_q;
        cont_d  = cont_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    start_d = start_ptr;
                    stop_d  = stop_ptr;
                    cont_d  = cont;
                    ptr_d   = start_ptr;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    // Equal pointers: empty one-shot, or a full ring when
                    // continuous (ptr+1 only meets stop after 2^ADDR_W beats).
                    if (start_ptr == stop_ptr && !cont) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = s_axis.tdata;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (ptr_inc == stop_q) begin
                        if (cont_q) begin
                            ptr_d = start_q;
                        end else begin
                            ptr_d = ptr_inc;
                            if (enable) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        ptr_d = ptr_inc;
                    end
                end
                // Abort wins over completion; the beat above is still written.
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            ptr_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            cont_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= enable;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            cont_q  <= cont_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_axis_capture_ptr.sv
// Directed bench for axis_capture_ptr: one task per scenario, inputs
// driven and outputs sampled on the falling edge of aclk.
module tb_axis_capture_ptr;

    localparam int DW = 512;
    localparam int AW = 12;
    localparam int CW = 13;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          enable = 1'b0;
    logic          cont = 1'b0;
    logic [AW-1:0] start_ptr = '0;
    logic [AW-1:0] stop_ptr = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic [CW-1:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    axis_capture_ptr_if #(.DATA_W(DW)) s_axis ();

    axis_capture_ptr #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .CNT_W (CW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_axis   (s_axis),
        .enable   (enable),
        .cont     (cont),
        .start_ptr(start_ptr),
        .stop_ptr (stop_ptr),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .beat_cnt (beat_cnt)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic [DW-1:0] d);
        s_axis.tvalid = v;
        s_axis.tdata  = d;
        @(negedge aclk);
    endtask

    task automatic arm(input logic [AW-1:0] s, input logic [AW-1:0] e,
                       input logic c);
        s_axis.tvalid = 1'b0;
        enable        = 1'b0;
        start_ptr     = s;
        stop_ptr      = e;
        cont          = c;
        @(negedge aclk);
        enable = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset;
        @(negedge aclk);
        checks++;
        if (s_axis.tready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy tready=%b busy=%b exp 0 0",
                     s_axis.tready, busy);
        end
        checks++;
        if (mem_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_we mem_we=%b done=%b exp 0 0", mem_we, done);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || beat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_bus addr=%h cnt=%h exp 0 0",
                     mem_addr, beat_cnt);
        end
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_oneshot;
        arm(12'd0, 12'd4, 1'b0);
        checks++;
        if (s_axis.tready !== 1'b1 || beat_cnt !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL os_arm tready=%b cnt=%0d done=%b exp 1 0 0",
                     s_axis.tready, beat_cnt, done);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(32'hA0 + i));
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(i) ||
                mem_wdata !== DW'(32'hA0 + i)) begin
                errors++;
                $display("FAIL os_wr%0d we=%b addr=%h data=%h exp 1 %h %h",
                         i, mem_we, mem_addr, mem_wdata[15:0], i, 32'hA0 + i);
            end
        end
        checks++;
        if (s_axis.tready !== 1'b0 || done !== 1'b1 ||
            beat_cnt !== CW'(4) || busy !== 1'b0) begin
            errors++;
            $display("FAIL os_end tready=%b done=%b cnt=%0d busy=%b exp 0 1 4 0",
                     s_axis.tready, done, beat_cnt, busy);
        end
        drive(1'b1, DW'(32'hA4));
        checks++;
        if (mem_we !== 1'b0 || beat_cnt !== CW'(4)) begin
            errors++;
            $display("FAIL os_extra we=%b cnt=%0d exp 0 4", mem_we, beat_cnt);
        end
        s_axis.tvalid = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL os_idle done=%b busy=%b exp 1 0", done, busy);
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] ea [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        arm(12'hFFE, 12'h002, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(32'hE0 + i));
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ea[i] ||
                mem_wdata !== DW'(32'hE0 + i)) begin
                errors++;
                $display("FAIL wrap_wr%0d we=%b addr=%h exp 1 %h",
                         i, mem_we, mem_addr, ea[i]);
            end
        end
        checks++;
        if (done !== 1'b1 || beat_cnt !== CW'(4)) begin
            errors++;
            $display("FAIL wrap_end done=%b cnt=%0d exp 1 4", done, beat_cnt);
        end
        s_axis.tvalid = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_continuous;
        arm(12'd2, 12'd5, 1'b1);
        start_ptr = 12'd9;
        stop_ptr  = 12'd11;
        cont      = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, DW'(32'hD0 + i));
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(2 + i % 3) ||
                mem_wdata !== DW'(32'hD0 + i)) begin
                errors++;
                $display("FAIL cont_wr%0d we=%b addr=%h exp 1 %h",
                         i, mem_we, mem_addr, 2 + i % 3);
            end
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || beat_cnt !== CW'(7)) begin
            errors++;
            $display("FAIL cont_run done=%b busy=%b cnt=%0d exp 0 1 7",
                     done, busy, beat_cnt);
        end
        s_axis.tvalid = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
        checks++;
        if (s_axis.tready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop tready=%b busy=%b we=%b exp 0 0 0",
                     s_axis.tready, busy, mem_we);
        end
    endtask

    task automatic test_gaps;
        logic v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int k = 0;
        arm(12'd0, 12'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(v[i], DW'(32'hB0 + k));
            checks++;
            if (v[i]) begin
                if (mem_we !== 1'b1 || mem_addr !== AW'(k) ||
                    mem_wdata !== DW'(32'hB0 + k)) begin
                    errors++;
                    $display("FAIL gap_wr%0d we=%b addr=%h exp 1 %h",
                             i, mem_we, mem_addr, k);
                end
                k++;
            end else if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle%0d we=%b exp 0", i, mem_we);
            end
        end
        checks++;
        if (done !== 1'b1 || beat_cnt !== CW'(3) || s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL gap_end done=%b cnt=%0d tready=%b exp 1 3 0",
                     done, beat_cnt, s_axis.tready);
        end
        s_axis.tvalid = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_abort_zero;
        arm(12'd0, 12'd8, 1'b0);
        drive(1'b1, DW'(32'hC0));
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== AW'(0)) begin
            errors++;
            $display("FAIL ab_wr0 we=%b addr=%h exp 1 0", mem_we, mem_addr);
        end
        enable = 1'b0;
        drive(1'b1, DW'(32'hC1));
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== AW'(1) ||
            mem_wdata !== DW'(32'hC1) || busy !== 1'b0) begin
            errors++;
            $display("FAIL ab_wr1 we=%b addr=%h busy=%b exp 1 1 0",
                     mem_we, mem_addr, busy);
        end
        drive(1'b1, DW'(32'hC2));
        checks++;
        if (mem_we !== 1'b0 || done !== 1'b0 || beat_cnt !== CW'(2) ||
            s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL ab_idle we=%b done=%b cnt=%0d tready=%b exp 0 0 2 0",
                     mem_we, done, beat_cnt, s_axis.tready);
        end
        arm(12'd7, 12'd7, 1'b0);
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0 ||
            s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len done=%b we=%b busy=%b exp 1 0 0",
                     done, mem_we, busy);
        end
        repeat (2) @(negedge aclk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || beat_cnt !== '0) begin
            errors++;
            $display("FAIL hold_high done=%b busy=%b cnt=%0d exp 1 0 0",
                     done, busy, beat_cnt);
        end
        enable = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_reset_mid;
        arm(12'd0, 12'd8, 1'b0);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = DW'(32'hE5);
        @(posedge aclk);
        #1;
        s_axis.tvalid = 1'b0;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_pend we=%b exp 1", mem_we);
        end
        areset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || s_axis.tready !== 1'b0 ||
            done !== 1'b0 || beat_cnt !== '0 || mem_addr !== '0 ||
            mem_wdata !== '0) begin
            errors++;
            $display("FAIL rst_async we=%b busy=%b cnt=%0d data=%h exp all 0",
                     mem_we, busy, beat_cnt, mem_wdata[15:0]);
        end
        enable = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        arm(12'd0, 12'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, DW'(32'hF0 + i));
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(i) ||
                mem_wdata !== DW'(32'hF0 + i)) begin
                errors++;
                $display("FAIL rearm_wr%0d we=%b addr=%h exp 1 %h",
                         i, mem_we, mem_addr, i);
            end
        end
        checks++;
        if (done !== 1'b1 || beat_cnt !== CW'(2)) begin
            errors++;
            $display("FAIL rearm_end done=%b cnt=%0d exp 1 2", done, beat_cnt);
        end
        s_axis.tvalid = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        test_reset();
        test_oneshot();
        test_wrap();
        test_continuous();
        test_gaps();
        test_abort_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
